// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for an RV32 subset (ALU-imm, load, bne).
// Drives datapath strobes, counts retired instructions and latches sticky faults.
module multicycle_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] instr,
  input  logic             imem_ready,
  input  logic             EQ,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCsrc,
  output logic             RegWrite,
  output logic             ALUctrl,
  output logic             ALUsrc,
  output logic [1:0]       ImmSrc,
  output logic             WD3select,
  output logic             dmem_req,
  output logic [CNT_W-1:0] retired,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [2:0]       o_dbg_state
);

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC_I = 3'd3,
    S_EXEC_B = 3'd4,
    S_MEM    = 3'd5,
    S_WB     = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [6:0]       r_opcode;
  logic [7:0]       r_wait;
  logic [CNT_W-1:0] r_retired;
  logic [1:0]       r_fault_code;
  logic             w_timeout;
  logic             w_retire;
  logic             w_unused;

  assign w_unused  = ^instr[WIDTH-1:7];
  assign w_timeout = (r_state == S_MEM) && !dmem_ready && (r_wait == WAIT_LAST);
  assign w_retire  = (r_state == S_EXEC_I) || (r_state == S_EXEC_B) || (r_state == S_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_START;
    else        r_state <= w_next;
  end

  // Request/ready handshake: a request (imem_req / dmem_req) stays high every
  // cycle until the matching ready is seen; the transfer completes in the cycle
  // where request and ready are both 1, and the FSM advances on that edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_START:  w_next = S_FETCH;
      S_FETCH:  if (imem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (r_opcode)
          OP_ALUI:   w_next = S_EXEC_I;
          OP_LOAD:   w_next = S_MEM;
          OP_BRANCH: w_next = S_EXEC_B;
          default:   w_next = S_FAULT;
        endcase
      end
      S_EXEC_I: w_next = S_FETCH;
      S_EXEC_B: w_next = S_FETCH;
      S_MEM: begin
        if (dmem_ready)     w_next = S_WB;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_WB:     w_next = S_FETCH;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_START;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCsrc     = 1'b0;
    RegWrite  = 1'b0;
    ALUctrl   = 1'b0;
    ALUsrc    = 1'b0;
    ImmSrc    = 2'b00;
    WD3select = 1'b0;
    dmem_req  = 1'b0;
    fault     = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        IRWrite  = imem_ready;
      end
      S_EXEC_I: begin
        ImmSrc   = 2'b10;
        ALUsrc   = 1'b1;
        ALUctrl  = 1'b1;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
      end
      S_EXEC_B: begin
        PCWrite = 1'b1;
        PCsrc   = !EQ;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        ImmSrc   = 2'b01;
        ALUsrc   = 1'b1;
        ALUctrl  = 1'b1;
      end
      S_WB: begin
        ImmSrc    = 2'b01;
        ALUsrc    = 1'b1;
        ALUctrl   = 1'b1;
        RegWrite  = 1'b1;
        WD3select = 1'b1;
        PCWrite   = 1'b1;
      end
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  // Datapath-side registers: opcode latch, MEM wait counter, retire count, fault cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode     <= 7'd0;
      r_wait       <= 8'd0;
      r_retired    <= '0;
      r_fault_code <= 2'b00;
    end else begin
      if (r_state == S_FETCH && imem_ready) r_opcode <= instr[6:0];
      if (r_state == S_DECODE) r_wait <= 8'd0;
      else if (r_state == S_MEM && !dmem_ready && !w_timeout) r_wait <= r_wait + 8'd1;
      if (w_retire) r_retired <= r_retired + 1'b1;
      if (r_fault_code == 2'b00) begin
        if (r_state == S_DECODE && w_next == S_FAULT) r_fault_code <= 2'b01;
        else if (w_timeout)                           r_fault_code <= 2'b10;
      end
    end
  end

  assign retired     = r_retired;
  assign fault_code  = r_fault_code;
  assign o_dbg_state = r_state;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32 datapath: PC, instruction register, register file, ALU, sign-extend unit, data memory. It replaces the single-cycle combinational decoder.
- Steps each instruction through fetch, decode, execute, memory and writeback states. It handshakes with instruction and data memories and drives the datapath control strobes.
- Supported subset: ALU-immediate (opcode 0010011), load (0000011) and branch-not-equal (1100011).
- Adds a retired-instruction counter and sticky fault reporting for illegal opcodes and data-memory timeouts.

Parameters:
- WIDTH, 32, instruction width.
- TIMEOUT, 15, maximum cycles in MEM with dmem_ready low before fault; legal range 1..255.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  WIDTH  instruction from instruction memory; only instr[6:0] is used, and it is sampled when IRWrite=1.
- imem_ready  in  1  instruction memory has valid instr this cycle.
- EQ  in  1  ALU equality flag.
- dmem_ready  in  1  data memory read data valid this cycle.
- imem_req  out  1  instruction fetch request.
- IRWrite  out  1  latch instr into the instruction register.
- PCWrite  out  1  update PC this cycle.
- PCsrc  out  1  0 = PC+4, 1 = PC+imm.
- RegWrite  out  1  register file write enable.
- ALUctrl  out  1  0 = compare/sub, 1 = add.
- ALUsrc  out  1  0 = rs2, 1 = immediate.
- ImmSrc  out  2  00 = B-type, 01 = I-type load, 10 = I-type ALU.
- WD3select  out  1  0 = ALU result, 1 = memory data.
- dmem_req  out  1  data memory read request.
- retired  out  CNT_W  count of completed instructions.
- fault  out  1  sticky fault flag.
- fault_code  out  2  00 none, 01 illegal opcode, 10 dmem timeout.

Behaviour:
- States: START, FETCH, DECODE, EXEC_I, EXEC_B, MEM, WB, FAULT.
- Reset: rst_n low forces state=START, opcode reg=0, retired=0, fault=0, fault_code=00 and the wait counter to 0, all immediately and asynchronously.
- Output defaults: every output is 0 except where a state below asserts it. ImmSrc defaults to 00.
- START: all outputs 0; always go to FETCH next cycle. This ensures no memory request and no IRWrite during or on the first cycle after reset release.
- FETCH: imem_req=1 and IRWrite=imem_ready (Mealy).
  - If imem_ready=1: opcode reg <= instr[6:0], go to DECODE.
  - Otherwise stay in FETCH indefinitely (no timeout on instruction fetch).
- DECODE: all strobes 0; one cycle. Next state by opcode reg:
  - 0010011 -> EXEC_I.
  - 0000011 -> MEM, clearing the wait counter.
  - 1100011 -> EXEC_B.
  - any other value -> FAULT with fault_code=01.
- EXEC_I: ImmSrc=10, ALUsrc=1, ALUctrl=1, RegWrite=1, WD3select=0, PCWrite=1, PCsrc=0; go to FETCH.
- EXEC_B: ImmSrc=00, ALUsrc=0, ALUctrl=0, PCWrite=1, PCsrc=!EQ (combinational from EQ this cycle); go to FETCH.
- MEM: dmem_req=1, ImmSrc=01, ALUsrc=1, ALUctrl=1.
  - If dmem_ready=1: go to WB. This has priority over timeout in the same cycle.
  - Else if the wait counter == TIMEOUT-1: go to FAULT with fault_code=10.
  - Else increment the wait counter.
  - Net effect: exactly TIMEOUT consecutive not-ready cycles cause a fault.
- WB: ImmSrc=01, ALUsrc=1, ALUctrl=1, RegWrite=1, WD3select=1, PCWrite=1, PCsrc=0; go to FETCH.
- Retired counter: increments by 1 on each exit from EXEC_I, EXEC_B or WB; wraps modulo 2^CNT_W (all-ones -> 0).
- FAULT: all strobes 0 and fault=1. fault_code holds the first cause. Only rst_n leaves FAULT.
- Per-instruction latency with zero memory wait: ALU-imm and branch take 3 cycles (FETCH, DECODE, EXEC); load takes 4 cycles (FETCH, DECODE, MEM, WB).
- Invariants:
  - PCWrite asserts exactly once per retired instruction.
  - RegWrite is never 1 in FETCH, DECODE, MEM, EXEC_B or FAULT.
- Reset mid-instruction: aborts immediately. No PCWrite or RegWrite in the START cycle that follows.

Test Plan:
- Reset release, imem_ready=1, instr=0x00500093 (addi) -> 1 START cycle, then FETCH/DECODE/EXEC_I. EXEC_I shows RegWrite=1, ImmSrc=10, ALUsrc=1, PCWrite=1, PCsrc=0. retired=1 after 4 cycles from reset release.
- instr=0x0000A103 (lw), dmem_ready low for 3 MEM cycles then high -> dmem_req=1 for 4 cycles, then WB with RegWrite=1 and WD3select=1. retired increments once; fault stays 0.
- instr=0xFE209EE3 (bne): EQ=0 -> EXEC_B shows PCWrite=1, PCsrc=1. Repeat with EQ=1 -> PCsrc=0. RegWrite=0 in both cases.
- instr=0x00000033 (opcode 0110011) -> FAULT after DECODE with fault=1 and fault_code=01. No further imem_req while imem_ready stays 1; retired unchanged.
- lw with dmem_ready held low, TIMEOUT=15 -> FAULT entered after exactly 15 MEM cycles, fault_code=10. Rerun with dmem_ready rising on the 15th MEM cycle -> WB, no fault.
- Counter wrap and reset: CNT_W=4, run 16 addi -> retired returns to 0. Assert rst_n low during MEM -> all outputs 0 asynchronously; fault and retired are cleared.
